trdb_packet_sched: RTL and testbench



---
 rtl/trdb_pkg.sv | 25 ++
 rtl/trdb_packet_sched_if.sv | 21 ++
 rtl/trdb_rr_arbiter.sv | 43 ++++
 rtl/trdb_packet_sched.sv | 139 +++++++++++++
 tb/tb_trdb_packet_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trdb_pkg.sv
// Shared constants, FSM encoding and width helpers for the trace-debug packet scheduler.
package trdb_pkg;

    localparam int unsigned TRDB_PACKET_LEN = 128;
    localparam int unsigned TRDB_WORD_LEN   = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned len_width(input int unsigned packet_len);
        return $clog2(packet_len) + 1;
    endfunction

    localparam int unsigned TRDB_LEN_W = len_width(TRDB_PACKET_LEN);

endpackage

// File: rtl/trdb_packet_sched_if.sv
// Serialized output-word stream between the packet scheduler and its consumer.
interface trdb_packet_sched_if #(
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned SRC_W    = 1
);
    logic                word_valid;
    logic                word_ready;
    logic [WORD_LEN-1:0] word;
    logic                word_last;
    logic [SRC_W-1:0]    word_src;

    modport master (
        output word_valid, word, word_last, word_src,
        input  word_ready
    );

    modport slave (
        input  word_valid, word, word_last, word_src,
        output word_ready
    );
endinterface

// File: rtl/trdb_rr_arbiter.sv
// Round-robin arbiter: picks the first active request after ptr_i, wrapping modulo NREQ.
module trdb_rr_arbiter
    import trdb_pkg::*;
#(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned SRC_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [SRC_W-1:0] idx_o,
    output logic             valid_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    // Rotating a doubled vector puts requester ptr+1 at bit 0.
    assign dbl = {req_i, req_i};
    assign rot = NREQ'(dbl >> (32'(ptr_i) + 32'd1));

    always_comb begin : sel
        int unsigned win;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        win     = 0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (rot[k-1]) begin
                win     = 32'(ptr_i) + k;
                valid_o = 1'b1;
            end
        end
        if (win >= NREQ) begin
            win = win - NREQ;
        end
        if (valid_o) begin
            gnt_o = NREQ'(1) << win;
            idx_o = SRC_W'(win);
        end
    end

endmodule

// File: rtl/trdb_packet_sched.sv
// Grants one of NREQ packet requesters round-robin and serializes its packet LSB-first
// into WORD_LEN-bit words on the output stream, with an idle cycle between packets.
module trdb_packet_sched
    import trdb_pkg::*;
#(
    parameter  int unsigned NREQ       = 2,
    parameter  int unsigned PACKET_LEN = TRDB_PACKET_LEN,
    parameter  int unsigned WORD_LEN   = TRDB_WORD_LEN,
    localparam int unsigned LEN_W      = len_width(PACKET_LEN),
    localparam int unsigned SRC_W      = idx_width(NREQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            flush_i,
    input  logic [NREQ-1:0]                 req_valid_i,
    output logic [NREQ-1:0]                 req_ready_o,
    input  logic [NREQ-1:0][PACKET_LEN-1:0] req_packet_i,
    input  logic [NREQ-1:0][LEN_W-1:0]      req_len_i,
    trdb_packet_sched_if.master             word_if,
    output logic                            busy_o
);

    localparam int unsigned NWORDS = PACKET_LEN / WORD_LEN;
    localparam int unsigned IDX_W  = idx_width(NWORDS);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [SRC_W-1:0]        ptr_q, ptr_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [PACKET_LEN-1:0]   pkt_q, pkt_d;

    logic [NREQ-1:0]         arb_gnt;
    logic [SRC_W-1:0]        arb_idx;
    logic                    arb_valid;
    logic                    grant;
    logic [LEN_W-1:0]        len_clamp;
    logic [PACKET_LEN-1:0]   pkt_mask;
    logic                    in_send;

    trdb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign in_send     = (state_q == SEND);
    assign grant       = rst_ni && !in_send && enable_i && !flush_i && arb_valid;
    assign req_ready_o = grant ? arb_gnt : '0;
    assign busy_o      = in_send;

    always_comb begin
        len_clamp = req_len_i[arb_idx];
        if (32'(len_clamp) > PACKET_LEN) begin
            len_clamp = LEN_W'(PACKET_LEN);
        end
        // Bits beyond the packet length are zeroed once here, so every word slice is clean.
        pkt_mask = '0;
        for (int unsigned b = 0; b < PACKET_LEN; b++) begin
            pkt_mask[b] = (b < 32'(len_clamp));
        end
    end

    always_comb begin
        int unsigned nwords;
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        pkt_d   = pkt_q;
        nwords  = (32'(len_clamp) + WORD_LEN - 1) / WORD_LEN;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    ptr_d = arb_idx;
                    src_d = arb_idx;
                    pkt_d = req_packet_i[arb_idx] & pkt_mask;
                    idx_d = '0;
                    if (nwords != 0) begin
                        last_d  = IDX_W'(nwords - 1);
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                // A flush wins over a same-cycle handshake; that word is dropped too.
                if (flush_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (word_if.word_ready) begin
                    if (idx_q == last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            ptr_q   <= SRC_W'(NREQ - 1);
            src_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        word_if.word_valid = in_send;
        word_if.word       = '0;
        word_if.word_last  = 1'b0;
        word_if.word_src   = '0;
        if (in_send) begin
            word_if.word      = WORD_LEN'(pkt_q >> (32'(idx_q) * WORD_LEN));
            word_if.word_last = (idx_q == last_q);
            word_if.word_src  = src_q;
        end
    end

endmodule

// File: tb/tb_trdb_packet_sched.sv
// Self-checking bench for trdb_packet_sched: cycle model + scoreboard, length table, directed corners.
`timescale 1ns/1ps
module tb_trdb_packet_sched;

    localparam int unsigned NREQ = 2;
    localparam int unsigned PL   = 128;
    localparam int unsigned WL   = 32;
    localparam int unsigned LW   = 8;
    localparam int unsigned SW   = 1;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable;
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][PL-1:0] req_packet;
    logic [NREQ-1:0][LW-1:0] req_len;
    logic                    busy;

    trdb_packet_sched_if #(.WORD_LEN(WL), .SRC_W(SW)) wif ();

    trdb_packet_sched #(
        .NREQ       (NREQ),
        .PACKET_LEN (PL),
        .WORD_LEN   (WL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_packet_i (req_packet),
        .req_len_i    (req_len),
        .word_if      (wif),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nwords   = 0;
    int nbusy    = 0;

    typedef struct {
        logic [WL-1:0] word;
        logic          last;
        logic [SW-1:0] src;
    } exp_t;

    typedef struct {
        logic [SW-1:0] src;
        int            cyc;
    } hs_t;

    typedef struct {
        int unsigned len;
        int unsigned words;
    } vec_t;

    exp_t sb[$];
    hs_t  hs_log[$];

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [WL-1:0] exp_word(logic [PL-1:0] pkt, int unsigned len, int unsigned w);
        logic [WL-1:0] r;
        int unsigned   l;
        l = (len > PL) ? PL : len;
        for (int unsigned b = 0; b < WL; b++) begin
            r[b] = ((w * WL + b) < l) ? pkt[w * WL + b] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [PL-1:0] rand_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc++;

    // Reference model of the scheduler, evaluated mid-cycle on stable inputs.
    logic        m_send = 1'b0;
    int unsigned m_ptr  = NREQ - 1;

    always @(negedge clk) begin : model
        logic [NREQ-1:0] exp_rdy;
        logic [SW-1:0]   g;
        logic            got;
        int unsigned     c;
        int unsigned     l;
        int unsigned     cnt;
        exp_t            e;
        exp_t            e2;
        if (!rst_n) begin
            chk("rst_word_valid", wif.word_valid, 0);
            chk("rst_word", wif.word, 0);
            chk("rst_word_last", wif.word_last, 0);
            chk("rst_word_src", wif.word_src, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            sb.delete();
            m_send = 1'b0;
            m_ptr  = NREQ - 1;
        end else begin
            exp_rdy = '0;
            got     = 1'b0;
            g       = '0;
            if (!m_send && enable && !flush) begin
                for (int unsigned k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (!got && req_valid[c[SW-1:0]]) begin
                        got = 1'b1;
                        g   = c[SW-1:0];
                    end
                end
            end
            if (got) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("word_valid", wif.word_valid, m_send);
            chk("busy", busy, m_send);
            if (busy) nbusy++;
            if (m_send) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got an expected word slot with empty scoreboard, expected at least one entry");
                end else begin
                    e = sb[0];
                    chk("word", wif.word, e.word);
                    chk("word_last", wif.word_last, e.last);
                    chk("word_src", wif.word_src, e.src);
                    if (flush) begin
                        while (sb.size() > 0) begin
                            e2 = sb.pop_front();
                            if (e2.last) break;
                        end
                        m_send = 1'b0;
                    end else if (wif.word_ready) begin
                        void'(sb.pop_front());
                        nwords++;
                        hs_log.push_back('{src: e.src, cyc: cyc});
                        if (e.last) m_send = 1'b0;
                    end
                end
            end else if (got) begin
                m_ptr = int'(g);
                l     = (int'(req_len[g]) > PL) ? PL : int'(req_len[g]);
                cnt   = (l + WL - 1) / WL;
                for (int unsigned w = 0; w < cnt; w++) begin
                    sb.push_back('{word: exp_word(req_packet[g], l, w), last: (w == cnt - 1), src: g});
                end
                if (l > 0) m_send = 1'b1;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        int unsigned n;
        n = 0;
        while ((busy || sb.size() != 0) && n < max_cyc) begin
            step(1);
            n++;
        end
        if (busy || sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max_cyc);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

    initial begin : stim
        vec_t vt[8];
        int   w0;
        int   b0;

        vt = '{'{70, 3}, '{32, 1}, '{1, 1}, '{33, 2}, '{96, 3}, '{128, 4}, '{200, 4}, '{0, 0}};

        req_valid      = '0;
        req_packet     = '0;
        req_len        = '0;
        enable         = 1'b0;
        flush          = 1'b0;
        wif.word_ready = 1'b0;
        rst_n          = 1'b0;
        step(3);
        chk("reset_valid", wif.word_valid, 0);
        chk("reset_word", wif.word, 0);
        chk("reset_busy", busy, 0);
        rst_n          = 1'b1;
        enable         = 1'b1;
        wif.word_ready = 1'b1;
        step(1);

        // Both requesters valid continuously: sources alternate, one word per two cycles.
        req_packet[0] = rand_pkt();
        req_packet[1] = rand_pkt();
        req_len[0]    = 8'd32;
        req_len[1]    = 8'd32;
        hs_log.delete();
        req_valid = 2'b11;
        step(8);
        req_valid = '0;
        wait_idle(10);
        chk("alt_count", hs_log.size(), 4);
        for (int i = 0; i < hs_log.size(); i++) begin
            chk("alt_src", hs_log[i].src, i % 2);
            if (i > 0) chk("alt_spacing", hs_log[i].cyc - hs_log[i-1].cyc, 2);
        end

        // Length table on requester 0: word count and busy cycles per packet.
        for (int i = 0; i < 8; i++) begin
            req_packet[0] = rand_pkt();
            req_len[0]    = LW'(vt[i].len);
            w0 = nwords;
            b0 = nbusy;
            req_valid = 2'b01;
            step(1);
            req_valid = '0;
            wait_idle(20);
            chk("tbl_words", nwords - w0, vt[i].words);
            chk("tbl_busy", nbusy - b0, vt[i].words);
        end

        // Back-pressure for five cycles on word 1 of a 3-word packet.
        req_packet[1] = rand_pkt();
        req_len[1]    = 8'd96;
        req_valid = 2'b10;
        step(1);
        req_valid = '0;
        step(1);
        wif.word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", wif.word_valid, 1);
            chk("stall_word", wif.word, exp_word(req_packet[1], 96, 1));
            chk("stall_last", wif.word_last, 0);
            chk("stall_src", wif.word_src, 1);
            step(1);
        end
        wif.word_ready = 1'b1;
        wait_idle(10);

        // Flush on word index 2 of a 4-word packet, then round-robin continues.
        req_packet[0] = rand_pkt();
        req_len[0]    = 8'd128;
        w0 = nwords;
        req_valid = 2'b01;
        step(1);
        req_valid = '0;
        step(2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_words", nwords - w0, 2);
        req_len[0] = 8'd32;
        req_len[1] = 8'd32;
        req_valid  = 2'b11;
        #1;
        chk("flush_rr", req_ready, 2'b10);
        step(1);
        req_valid = '0;
        wait_idle(10);

        // Zero-length grant on req1, then oversize length on req0 clamps to 4 words.
        req_len[1] = 8'd0;
        w0 = nwords;
        req_valid = 2'b10;
        #1;
        chk("len0_ready", req_ready, 2'b10);
        step(1);
        req_valid = '0;
        chk("len0_busy", busy, 0);
        step(2);
        chk("len0_words", nwords - w0, 0);
        req_packet[0] = rand_pkt();
        req_len[0]    = 8'd200;
        w0 = nwords;
        req_valid = 2'b01;
        #1;
        chk("clamp_ready", req_ready, 2'b01);
        step(1);
        req_valid = '0;
        wait_idle(10);
        chk("clamp_words", nwords - w0, 4);

        // enable low blocks grants; flush in IDLE blocks grants; dropping enable mid-packet lets it finish.
        enable     = 1'b0;
        req_len[0] = 8'd96;
        req_valid  = 2'b01;
        #1;
        chk("dis_ready", req_ready, 0);
        step(2);
        chk("dis_busy", busy, 0);
        enable = 1'b1;
        flush  = 1'b1;
        #1;
        chk("idle_flush_ready", req_ready, 0);
        step(1);
        flush = 1'b0;
        w0 = nwords;
        #1;
        chk("en_ready", req_ready, 2'b01);
        step(1);
        req_valid = '0;
        enable    = 1'b0;
        wait_idle(10);
        chk("en_drop_words", nwords - w0, 3);
        enable = 1'b1;

        // Asynchronous reset in the middle of a packet.
        req_packet[1] = rand_pkt();
        req_len[1]    = 8'd128;
        req_valid = 2'b10;
        step(1);
        req_valid = '0;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", wif.word_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_word", wif.word, 0);
        chk("arst_last", wif.word_last, 0);
        step(2);
        rst_n      = 1'b1;
        req_len[0] = 8'd64;
        req_len[1] = 8'd64;
        req_valid  = 2'b11;
        #1;
        chk("post_rst_ready", req_ready, 2'b01);
        step(1);
        req_valid = '0;
        wait_idle(10);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
